decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, 16, width of register data, PC and immediates (16..32).
REQ-002 Parameter NREGS, 16, number of architectural registers (2..16); register addresses stay 4 bits.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 validD  in  1  inst/PCD/PCPlus2 carry a real instruction.
REQ-006 inst  in  16  instruction word.
REQ-007 PCD, PCPlus2  in  DATA_W each  PC of inst, PC+2.
REQ-008 regWriteWB  in  1  writeback enable.
REQ-009 RdestW  in  4  writeback register address.
REQ-010 resultWB  in  DATA_W  writeback data.
REQ-011 flushE  in  1  kill the instruction entering execute.
REQ-012 holdE  in  1  downstream backpressure; freeze the ID/EX register.
REQ-013 stallD  out  1  fetch must hold inst/PCD/PCPlus2 this cycle.
REQ-014 validE, illegalE  out  1 each  execute-stage valid, illegal opcode.
REQ-015 RD1E, RD2E, immExtE, PCE, PCPlus2E  out  DATA_W each  operands, immediate, PCs.
REQ-016 Rs1E, Rs2E, RdE  out  4 each  source/destination addresses for forwarding.
REQ-017 regWriteE, memWriteE, jumpE, branchE, aluSrcE  out  1 each  controls.
REQ-018 aluControlE  out  3; resultSrcE  out  2.

Function
REQ-019 op=inst[15:12]; R-type (op 1-4): rd=[11:8], rs1=[7:4], rs2=[3:0], imm=0.
REQ-020 I/load (op 5,6): rd=[11:8], rs1=[7:4], rs2=0, imm=sext(inst[3:0]); store/branch (op 7,8): rs2=[11:8], rs1=[7:4], rd=0, imm=sext(inst[3:0]); JAL (op 9): rd=[11:8], rs1=rs2=0, imm=sext(inst[7:0]); all sign extension to DATA_W.
REQ-021 Controls {regWrite,memWrite,jump,branch,aluSrc,aluControl,resultSrc}: 0 NOP all 0; 1 ADD 1,0,0,0,0,000,00; 2 SUB aluControl 001; 3 AND 010; 4 OR 011; 5 ADDI 1,0,0,0,1,000,00; 6 LW 1,0,0,0,1,000,01; 7 SW 0,1,0,0,1,000,00; 8 BEQ 0,0,0,1,0,001,00; 9 JAL 1,0,1,0,0,000,10.
REQ-022 Opcodes A-F: all controls 0, illegalE=1 with validE=1.
REQ-023 Register file NREGS x DATA_W; write at rising edge when regWriteWB=1, RdestW!=0, RdestW<NREGS; register 0 and addresses >=NREGS read 0.
REQ-024 Load-use hazard = validD & validE & resultSrcE==01 & RdE!=0 & (RdE==rs1 | RdE==rs2), decoded fields per REQ-019/020.
REQ-025 stallD = hazard | holdE, combinational.
REQ-026 ID/EX update priority per edge: flushE -> bubble; else holdE -> all outputs hold; else hazard -> bubble; else load decoded values, latency one cycle.
REQ-027 Bubble: validE=0, illegalE=0, all controls 0, RD1E/RD2E/immExtE/PCE/PCPlus2E/Rs1E/Rs2E/RdE 0.
REQ-028 Load with validD=0 produces a bubble.

Reset
REQ-029 rst=1 immediately forces every output and every register-file entry to 0 regardless of clk, including mid-hold or mid-hazard; first load occurs on first rising edge with rst=0.

Configuration
REQ-030 DECODE_WB_BYPASS_EN defined: a read whose address equals RdestW in a cycle with a valid write (REQ-023) returns resultWB that same cycle; undefined: it returns the previously stored value; register writes identical in both builds.

Verification
REQ-031 rst=1, inst=16'h6103, validD=1 -> all outputs 0; release, one edge -> validE=1, RdE=1, Rs1E=0, immExtE=0003, aluSrcE=1, regWriteE=1, resultSrcE=01.
REQ-032 regWriteWB=1, RdestW=1, resultWB=0010, inst=16'h1212 after reset -> RD1E=0010 with macro, 0000 without; next ADD reads 0010 in both builds.
REQ-033 LW 16'h6103 then ADD 16'h1312 -> stallD=1 one cycle, next edge bubble (validE=0), following edge ADD loads with Rs1E=1.
REQ-034 holdE=1 three cycles -> outputs unchanged, stallD=1; holdE=1 with flushE=1 -> bubble.
REQ-035 16'h94F0 -> jumpE=1, RdE=4, immExtE=FFF0, resultSrcE=10; 16'h521F -> immExtE=FFFF; 16'hB000 -> illegalE=1, controls 0.
REQ-036 regWriteWB=1, RdestW=0, resultWB=1234 then read r0 -> RD1E=0000.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction decode stage of a 16-bit-instruction pipeline.
//               Decodes the instruction and reads the register file. Detects
//               load-use hazards, generates stallD, and holds the ID/EX
//               pipeline register that feeds execute.
//               Optional build macro DECODE_WB_BYPASS_EN: when defined, a
//               register read whose address matches the writeback address in
//               a cycle with a valid write returns resultWB that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validD,
  input  logic [15:0]       inst,
  input  logic [DATA_W-1:0] PCD,
  input  logic [DATA_W-1:0] PCPlus2,
  input  logic              regWriteWB,
  input  logic [3:0]        RdestW,
  input  logic [DATA_W-1:0] resultWB,
  input  logic              flushE,
  input  logic              holdE,
  output logic              stallD,
  output logic              validE,
  output logic              illegalE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] immExtE,
  output logic [DATA_W-1:0] PCE,
  output logic [DATA_W-1:0] PCPlus2E,
  output logic [3:0]        Rs1E,
  output logic [3:0]        Rs2E,
  output logic [3:0]        RdE,
  output logic              regWriteE,
  output logic              memWriteE,
  output logic              jumpE,
  output logic              branchE,
  output logic              aluSrcE,
  output logic [2:0]        aluControlE,
  output logic [1:0]        resultSrcE
);

  // Index width of the physical register array.
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  // Bit i set when architectural address i exists in this configuration.
  localparam logic [15:0] ADDR_OK = 16'((32'd1 << NREGS) - 32'd1);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC2 = 2'b10;

  // Everything that crosses into execute; an all-zero value is a bubble.
  typedef struct packed {
    logic              valid;
    logic              illegal;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus2;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [3:0]        rd;
    logic              reg_write;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              alu_src;
    logic [2:0]        alu_control;
    logic [1:0]        result_src;
  } idex_t;

  logic [3:0]        op;
  logic [3:0]        dec_rd;
  logic [3:0]        dec_rs1;
  logic [3:0]        dec_rs2;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_illegal;
  logic              dec_reg_write;
  logic              dec_mem_write;
  logic              dec_jump;
  logic              dec_branch;
  logic              dec_alu_src;
  logic [2:0]        dec_alu_control;
  logic [1:0]        dec_result_src;
  logic [DATA_W-1:0] imm4_sext;
  logic [DATA_W-1:0] imm8_sext;

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic              wb_we;
  logic [DATA_W-1:0] rd1_val;
  logic [DATA_W-1:0] rd2_val;

  logic              hazard;
  idex_t             idex_q;
  idex_t             idex_d;

  assign op        = inst[15:12];
  assign imm4_sext = {{(DATA_W-4){inst[3]}}, inst[3:0]};
  assign imm8_sext = {{(DATA_W-8){inst[7]}}, inst[7:0]};

  // Writes to r0 or to addresses beyond the implemented array are dropped.
  assign wb_we = regWriteWB && (RdestW != 4'd0) && ADDR_OK[RdestW];

  // Instruction field extraction and control generation.
  always_comb begin
    dec_rd          = 4'd0;
    dec_rs1         = 4'd0;
    dec_rs2         = 4'd0;
    dec_imm         = '0;
    dec_illegal     = 1'b0;
    dec_reg_write   = 1'b0;
    dec_mem_write   = 1'b0;
    dec_jump        = 1'b0;
    dec_branch      = 1'b0;
    dec_alu_src     = 1'b0;
    dec_alu_control = 3'b000;
    dec_result_src  = RES_ALU;
    case (op)
      OP_NOP: begin
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec_rd        = inst[11:8];
        dec_rs1       = inst[7:4];
        dec_rs2       = inst[3:0];
        dec_reg_write = 1'b1;
        case (op)
          OP_SUB:  dec_alu_control = 3'b001;
          OP_AND:  dec_alu_control = 3'b010;
          OP_OR:   dec_alu_control = 3'b011;
          default: dec_alu_control = 3'b000;
        endcase
      end
      OP_ADDI, OP_LW: begin
        dec_rd        = inst[11:8];
        dec_rs1       = inst[7:4];
        dec_imm       = imm4_sext;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        if (op == OP_LW) begin
          dec_result_src = RES_MEM;
        end
      end
      OP_SW: begin
        dec_rs2       = inst[11:8];
        dec_rs1       = inst[7:4];
        dec_imm       = imm4_sext;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OP_BEQ: begin
        dec_rs2         = inst[11:8];
        dec_rs1         = inst[7:4];
        dec_imm         = imm4_sext;
        dec_branch      = 1'b1;
        dec_alu_control = 3'b001;
      end
      OP_JAL: begin
        dec_rd         = inst[11:8];
        dec_imm        = imm8_sext;
        dec_reg_write  = 1'b1;
        dec_jump       = 1'b1;
        dec_result_src = RES_PC2;
      end
      default: begin
        // Opcodes A-F: flagged illegal, fields left zero so nothing executes.
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Register-file read ports, with optional same-cycle writeback bypass.
  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if ((dec_rs1 != 4'd0) && ADDR_OK[dec_rs1]) begin
      rd1_val = rf_q[dec_rs1[AW-1:0]];
    end
    if ((dec_rs2 != 4'd0) && ADDR_OK[dec_rs2]) begin
      rd2_val = rf_q[dec_rs2[AW-1:0]];
    end
`ifdef DECODE_WB_BYPASS_EN
    if (wb_we && (RdestW == dec_rs1)) begin
      rd1_val = resultWB;
    end
    if (wb_we && (RdestW == dec_rs2)) begin
      rd2_val = resultWB;
    end
`else
`endif
  end

  // Register-file next state: at most one entry changes per cycle.
  always_comb begin
    rf_d = rf_q;
    if (wb_we) begin
      rf_d[RdestW[AW-1:0]] = resultWB;
    end
  end

  // Register-file storage, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // A load in execute whose destination feeds this instruction must wait.
  assign hazard = validD && idex_q.valid && (idex_q.result_src == RES_MEM) &&
                  (idex_q.rd != 4'd0) &&
                  ((idex_q.rd == dec_rs1) || (idex_q.rd == dec_rs2));

  assign stallD = hazard | holdE;

  // ID/EX next state: flush beats hold, hold beats hazard bubble.
  always_comb begin
    idex_d = idex_q;
    if (flushE) begin
      idex_d = '0;
    end else if (holdE) begin
      idex_d = idex_q;
    end else if (hazard || !validD) begin
      idex_d = '0;
    end else begin
      idex_d.valid       = 1'b1;
      idex_d.illegal     = dec_illegal;
      idex_d.rd1         = rd1_val;
      idex_d.rd2         = rd2_val;
      idex_d.imm         = dec_imm;
      idex_d.pc          = PCD;
      idex_d.pc_plus2    = PCPlus2;
      idex_d.rs1         = dec_rs1;
      idex_d.rs2         = dec_rs2;
      idex_d.rd          = dec_rd;
      idex_d.reg_write   = dec_reg_write;
      idex_d.mem_write   = dec_mem_write;
      idex_d.jump        = dec_jump;
      idex_d.branch      = dec_branch;
      idex_d.alu_src     = dec_alu_src;
      idex_d.alu_control = dec_alu_control;
      idex_d.result_src  = dec_result_src;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign validE      = idex_q.valid;
  assign illegalE    = idex_q.illegal;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign immExtE     = idex_q.imm;
  assign PCE         = idex_q.pc;
  assign PCPlus2E    = idex_q.pc_plus2;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign regWriteE   = idex_q.reg_write;
  assign memWriteE   = idex_q.mem_write;
  assign jumpE       = idex_q.jump;
  assign branchE     = idex_q.branch;
  assign aluSrcE     = idex_q.alu_src;
  assign aluControlE = idex_q.alu_control;
  assign resultSrcE  = idex_q.result_src;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage. Each directed vector
//               pushes its expected stallD and expected post-edge outputs;
//               a separate monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [15:0] pcp2;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [9:0]  ctrl;  // {regWrite,memWrite,jump,branch,aluSrc,aluControl,resultSrc}
  } obs_t;

  typedef struct {
    string nm;
    logic  stall;
    logic  now;   // also require all-zero outputs before the edge (reset)
    obs_t  o;
  } item_t;

  localparam logic [9:0] C_NONE = 10'b0000000000;
  localparam logic [9:0] C_ADD  = 10'b1000000000;
  localparam logic [9:0] C_SUB  = 10'b1000000100;
  localparam logic [9:0] C_AND  = 10'b1000001000;
  localparam logic [9:0] C_OR   = 10'b1000001100;
  localparam logic [9:0] C_ADDI = 10'b1000100000;
  localparam logic [9:0] C_LW   = 10'b1000100001;
  localparam logic [9:0] C_SW   = 10'b0100100000;
  localparam logic [9:0] C_BEQ  = 10'b0001000100;
  localparam logic [9:0] C_JAL  = 10'b1010000010;

`ifdef DECODE_WB_BYPASS_EN
  localparam logic [15:0] BYP_R1 = 16'h0010;
  localparam logic [15:0] BYP_R2 = 16'h00AB;
`else
  localparam logic [15:0] BYP_R1 = 16'h0000;
  localparam logic [15:0] BYP_R2 = 16'h0000;
`endif

  localparam obs_t BUB = '0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        validD = 1'b0;
  logic [15:0] inst = 16'h0;
  logic [15:0] PCD = 16'h0;
  logic [15:0] PCPlus2 = 16'h0;
  logic        regWriteWB = 1'b0;
  logic [3:0]  RdestW = 4'h0;
  logic [15:0] resultWB = 16'h0;
  logic        flushE = 1'b0;
  logic        holdE = 1'b0;
  logic        stallD;
  logic        validE, illegalE;
  logic [15:0] RD1E, RD2E, immExtE, PCE, PCPlus2E;
  logic [3:0]  Rs1E, Rs2E, RdE;
  logic        regWriteE, memWriteE, jumpE, branchE, aluSrcE;
  logic [2:0]  aluControlE;
  logic [1:0]  resultSrcE;

  item_t sb[$];
  int    n_vec = 0;
  int    n_bad = 0;

  decode_stage #(.DATA_W(16), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .validD(validD), .inst(inst), .PCD(PCD),
    .PCPlus2(PCPlus2), .regWriteWB(regWriteWB), .RdestW(RdestW),
    .resultWB(resultWB), .flushE(flushE), .holdE(holdE), .stallD(stallD),
    .validE(validE), .illegalE(illegalE), .RD1E(RD1E), .RD2E(RD2E),
    .immExtE(immExtE), .PCE(PCE), .PCPlus2E(PCPlus2E), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .RdE(RdE), .regWriteE(regWriteE), .memWriteE(memWriteE),
    .jumpE(jumpE), .branchE(branchE), .aluSrcE(aluSrcE),
    .aluControlE(aluControlE), .resultSrcE(resultSrcE)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic v, input logic il,
                              input logic [15:0] rd1, input logic [15:0] rd2,
                              input logic [15:0] imm, input logic [15:0] pc,
                              input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic [3:0] rd, input logic [9:0] ctrl);
    obs_t o;
    o.valid = v;  o.illegal = il;
    o.rd1 = rd1;  o.rd2 = rd2;  o.imm = imm;
    o.pc = pc;    o.pcp2 = pc + 16'd2;
    o.rs1 = rs1;  o.rs2 = rs2;  o.rd = rd;
    o.ctrl = ctrl;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {validE, illegalE, RD1E, RD2E, immExtE, PCE, PCPlus2E, Rs1E, Rs2E,
         RdE, regWriteE, memWriteE, jumpE, branchE, aluSrcE, aluControlE,
         resultSrcE};
    return o;
  endfunction

  task automatic step(input string nm, input logic r, input logic vd,
                      input logic [15:0] ins, input logic [15:0] pc,
                      input logic we, input logic [3:0] wa,
                      input logic [15:0] wd, input logic fl, input logic hd,
                      input logic exp_stall, input logic now, input obs_t e);
    item_t it;
    @(negedge clk);
    rst = r;  validD = vd;  inst = ins;  PCD = pc;  PCPlus2 = pc + 16'd2;
    regWriteWB = we;  RdestW = wa;  resultWB = wd;
    flushE = fl;  holdE = hd;
    it.nm = nm;  it.stall = exp_stall;  it.now = now;  it.o = e;
    sb.push_back(it);
  endtask

  // Monitor: stallD just after inputs settle, outputs just after the edge.
  initial begin
    item_t it;
    obs_t  got;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        n_vec++;
        if (stallD !== it.stall) begin
          n_bad++;
          $display("FAIL %s stallD got=%b exp=%b", it.nm, stallD, it.stall);
        end
        if (it.now) begin
          n_vec++;
          got = sample();
          if (got !== BUB) begin
            n_bad++;
            $display("FAIL %s async_clear got=%h exp=%h", it.nm, got, BUB);
          end
        end
        @(posedge clk);
        #1;
        n_vec++;
        got = sample();
        if (got !== it.o) begin
          n_bad++;
          $display("FAIL %s outputs got=%h exp=%h", it.nm, got, it.o);
        end
      end
    end
  end

  // Stimulus: name, rst, validD, inst, PC, wb en/addr/data, flush, hold,
  // expected stallD, immediate-clear check, expected outputs after the edge.
  initial begin
    obs_t o_or, o_lw7;
    o_or  = mk(1, 0, 16'h0010, 16'h00AB, 16'h0000, 16'h0070, 1, 2, 3, C_OR);
    o_lw7 = mk(1, 0, 16'h0000, 16'h0000, 16'h0003, 16'h00B0, 0, 0, 7, C_LW);

    step("rst_hold", 1, 1, 16'h6103, 16'h0010, 0, 0, 0, 0, 0, 0, 1, BUB);
    step("lw_load",  0, 1, 16'h6103, 16'h0010, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0000, 16'h0000, 16'h0003, 16'h0010, 0, 0, 1, C_LW));
    step("lu_stall", 0, 1, 16'h1312, 16'h0012, 0, 0, 0, 0, 0, 1, 0, BUB);
    step("lu_add",   0, 1, 16'h1312, 16'h0012, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0012, 1, 2, 3, C_ADD));
    step("wb_same",  0, 1, 16'h1212, 16'h0020, 1, 1, 16'h0010, 0, 0, 0, 0,
         mk(1, 0, BYP_R1, 16'h0000, 16'h0000, 16'h0020, 1, 2, 2, C_ADD));
    step("wb_after", 0, 1, 16'h1212, 16'h0024, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0024, 1, 2, 2, C_ADD));
    step("r0_wr",    0, 1, 16'h1000, 16'h0030, 1, 0, 16'h1234, 0, 0, 0, 0,
         mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0030, 0, 0, 0, C_ADD));
    step("r0_rd",    0, 1, 16'h1000, 16'h0034, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0034, 0, 0, 0, C_ADD));
    step("sub_byp",  0, 1, 16'h2312, 16'h0040, 1, 2, 16'h00AB, 0, 0, 0, 0,
         mk(1, 0, 16'h0010, BYP_R2, 16'h0000, 16'h0040, 1, 2, 3, C_SUB));
    step("jal",      0, 1, 16'h94F0, 16'h0050, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0000, 16'h0000, 16'hFFF0, 16'h0050, 0, 0, 4, C_JAL));
    step("addi",     0, 1, 16'h521F, 16'h0054, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0010, 16'h0000, 16'hFFFF, 16'h0054, 1, 0, 2, C_ADDI));
    step("illegal",  0, 1, 16'hB000, 16'h0058, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0058, 0, 0, 0, C_NONE));
    step("sw",       0, 1, 16'h7321, 16'h0060, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h00AB, 16'h0000, 16'h0001, 16'h0060, 2, 3, 0, C_SW));
    step("beq",      0, 1, 16'h8128, 16'h0064, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h00AB, 16'h0010, 16'hFFF8, 16'h0064, 2, 1, 0, C_BEQ));
    step("or",       0, 1, 16'h4312, 16'h0070, 0, 0, 0, 0, 0, 0, 0, o_or);
    for (int i = 0; i < 3; i++) begin
      step("hold",   0, 1, 16'h3120, 16'h0080, 0, 0, 0, 0, 1, 1, 0, o_or);
    end
    step("hold_flush", 0, 1, 16'h3120, 16'h0080, 0, 0, 0, 1, 1, 1, 0, BUB);
    step("and",      0, 1, 16'h3120, 16'h0080, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h00AB, 16'h0000, 16'h0000, 16'h0080, 2, 0, 1, C_AND));
    step("no_valid", 0, 0, 16'h1312, 16'h0084, 0, 0, 0, 0, 0, 0, 0, BUB);
    step("lw5",      0, 1, 16'h6503, 16'h0090, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0000, 16'h0000, 16'h0003, 16'h0090, 0, 0, 5, C_LW));
    step("lu_rs2",   0, 1, 16'h1205, 16'h0094, 0, 0, 0, 0, 0, 1, 0, BUB);
    step("lu_rs2_go", 0, 1, 16'h1205, 16'h0094, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0094, 0, 5, 2, C_ADD));
    step("nop",      0, 1, 16'h0000, 16'h00A0, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h00A0, 0, 0, 0, C_NONE));
    step("lw7",      0, 1, 16'h6703, 16'h00B0, 0, 0, 0, 0, 0, 0, 0, o_lw7);
    step("hold_lw7", 0, 1, 16'h1312, 16'h00B4, 0, 0, 0, 0, 1, 1, 0, o_lw7);
    step("rst_mid",  1, 1, 16'h1312, 16'h00B4, 0, 0, 0, 0, 1, 1, 1, BUB);
    step("rf_clr",   0, 1, 16'h1312, 16'h00C0, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h00C0, 1, 2, 3, C_ADD));
    step("lw_r0",    0, 1, 16'h6003, 16'h00D0, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0000, 16'h0000, 16'h0003, 16'h00D0, 0, 0, 0, C_LW));
    step("no_lu_r0", 0, 1, 16'h1000, 16'h00D4, 0, 0, 0, 0, 0, 0, 0,
         mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h00D4, 0, 0, 0, C_ADD));

    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Watchdog against a stuck simulation.
  initial begin
    #20000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
